// File: rtl/fp_unit_wb_buffer.sv
// ---------------------------------------------------------------------------
// fp_unit_wb_buffer
//
// Writeback-side result buffer for a pipelined FP execution unit. Completed
// results {id, data} enter a small in-order FIFO. The head entry is presented
// to the FP writeback stage as done/id/rd and retires when writeback acks it.
// While the FIFO holds entries the unit pipeline can keep issuing. The unit
// sees backpressure only through result_ready.
//
// Ports:
//   clk           core clock
//   rst           asynchronous, active-high reset
//   result_valid  unit presents a completed result this cycle
//   result_id     ID of the presented result
//   result_data   value of the presented result
//   result_ready  buffer can accept a result this cycle (not full)
//   wb_done       head entry valid toward writeback
//   wb_id         head entry ID (0 when wb_done=0)
//   wb_rd         head entry data (0 when wb_done=0)
//   wb_ack        writeback consumed the head entry this cycle
//   count         current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fp_unit_wb_buffer #(
    parameter int DEPTH    = 2,
    parameter int ID_WIDTH = 3,
    parameter int FLEN     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     result_valid,
    input  logic [ID_WIDTH-1:0]      result_id,
    input  logic [FLEN-1:0]          result_data,
    output logic                     result_ready,
    output logic                     wb_done,
    output logic [ID_WIDTH-1:0]      wb_id,
    output logic [FLEN-1:0]          wb_rd,
    input  logic                     wb_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer wrap relies on DEPTH being a power of two. Occupancy comes from
    // the counter, so the pointers need no extra wrap bit.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fp_unit_wb_buffer: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [FLEN-1:0]     data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    // Ready and done are decoded from the registered count only. That keeps
    // wb_ack out of the result_ready path. It also means a fresh result is
    // never bypassed to the head in the cycle it arrives.
    assign result_ready = (count_q != CNT_W'(DEPTH));
    assign wb_done      = (count_q != '0);
    assign count        = count_q;

    // A result offered while full is dropped. An ack with nothing at the
    // head is ignored.
    assign push = result_valid & result_ready;
    assign pop  = wb_ack & wb_done;

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make update order matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;   // idle, or push and pop together
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array is deliberately left out of reset. Entries are
    // only observable through the head mux, and that mux is gated by count.
    // A reset is therefore redundant and would stop the array mapping onto
    // plain RAM/flop banks without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{id: result_id, data: result_data};
        end
    end

    // -----------------------------------------------------------------------
    // Head presentation
    // -----------------------------------------------------------------------
    // Outputs are forced to zero when empty. Unwritten RAM contents therefore
    // never reach writeback as X, either after reset or after a drain.
    // NOTE: defaults are assigned first so every path drives both outputs and
    // no latch is inferred.
    always_comb begin
        wb_id = '0;
        wb_rd = '0;
        if (wb_done) begin
            wb_id = mem[rd_ptr].id;
            wb_rd = mem[rd_ptr].data;
        end
    end

    // -----------------------------------------------------------------------
    // Protocol checking (simulation only)
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    // The unit must not offer a result while the buffer is full. If it does,
    // the result is lost. This warns rather than stopping so the drop
    // behaviour itself can still be observed.
    a_no_valid_when_full: assert property (
        @(posedge clk) disable iff (rst) result_valid |-> result_ready
    ) else $warning("fp_unit_wb_buffer: result_valid while result_ready=0, result dropped");
`endif

endmodule

// File: tb/tb_fp_unit_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_fp_unit_wb_buffer
//
// Directed, scoreboard-based bench for fp_unit_wb_buffer (DEPTH=2, ID_WIDTH=3,
// FLEN=64). The stimulus process queues the expected {id, data} for every
// result it expects the buffer to accept. A monitor running on the falling
// edge compares the presented head against the queue front. It retires the
// front whenever writeback acks a valid head. Occupancy, ready and done are
// checked directly by the stimulus process after each rising edge.
// ---------------------------------------------------------------------------
module tb_fp_unit_wb_buffer;

    localparam int DEPTH    = 2;
    localparam int ID_WIDTH = 3;
    localparam int FLEN     = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   result_valid;
    logic [ID_WIDTH-1:0]    result_id;
    logic [FLEN-1:0]        result_data;
    logic                   result_ready;
    logic                   wb_done;
    logic [ID_WIDTH-1:0]    wb_id;
    logic [FLEN-1:0]        wb_rd;
    logic                   wb_ack;
    logic [$clog2(DEPTH):0] count;

    // Writeback either follows an explicit ack from the stimulus or acks
    // done combinationally (streaming mode).
    logic ack_drv;
    logic ack_follow;
    assign wb_ack = ack_follow ? wb_done : ack_drv;

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        logic [FLEN-1:0]     data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fp_unit_wb_buffer #(
        .DEPTH   (DEPTH),
        .ID_WIDTH(ID_WIDTH),
        .FLEN    (FLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .result_valid(result_valid),
        .result_id   (result_id),
        .result_data (result_data),
        .result_ready(result_ready),
        .wb_done     (wb_done),
        .wb_id       (wb_id),
        .wb_rd       (wb_rd),
        .wb_ack      (wb_ack),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge. Inputs change and outputs are
    // sampled 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [ID_WIDTH-1:0] id, input logic [FLEN-1:0] data,
                         input bit expect_accept);
        result_valid = 1'b1;
        result_id    = id;
        result_data  = data;
        if (expect_accept) exp_q.push_back('{id: id, data: data});
    endtask

    task automatic idle_inputs();
        result_valid = 1'b0;
        result_id    = '0;
        result_data  = '0;
        ack_drv      = 1'b0;
    endtask

    task automatic check_state(input string tag, input int exp_count);
        check({tag, "_count"}, 64'(count), 64'(exp_count));
        check({tag, "_ready"}, 64'(result_ready), 64'(exp_count != DEPTH));
        check({tag, "_done"},  64'(wb_done),      64'(exp_count != 0));
    endtask

    task automatic drain();
        ack_drv = 1'b1;
        repeat (DEPTH) tick();
        ack_drv = 1'b0;
        check_state("drain", 0);
    endtask

    // Scoreboard monitor: compare the head whenever writeback sees a valid
    // entry. Retire the front when that entry is acked at the coming edge.
    always @(negedge clk) begin
        if (!rst && wb_done) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'(1));
            end else begin
                check("sb_id",   64'(wb_id), 64'(exp_q[0].id));
                check("sb_data", wb_rd,      exp_q[0].data);
                if (wb_ack) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        ack_follow = 1'b0;
        idle_inputs();
        rst = 1'b1;

        // Reset and idle.
        #12;
        check_state("in_reset", 0);
        check("in_reset_id", 64'(wb_id), 64'(0));
        check("in_reset_rd", wb_rd,      64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        check_state("idle", 0);
        check("idle_id", 64'(wb_id), 64'(0));
        check("idle_rd", wb_rd,      64'(0));

        // Single push, held without ack for 10 cycles, then one ack.
        offer(3'd5, 64'h3FF0_0000_0000_0000, 1'b1);
        tick();
        idle_inputs();
        check_state("single", 1);
        check("single_id", 64'(wb_id), 64'(5));
        check("single_rd", wb_rd,      64'h3FF0_0000_0000_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_id", 64'(wb_id), 64'(5));
            check("hold_rd", wb_rd,      64'h3FF0_0000_0000_0000);
        end
        check_state("hold", 1);
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        check_state("single_ack", 0);

        // Fill to DEPTH, offer one more that must be dropped, then ack once.
        offer(3'd1, 64'hC000_0000_0000_0001, 1'b1);
        tick();
        offer(3'd2, 64'hC000_0000_0000_0002, 1'b1);
        tick();
        idle_inputs();
        check_state("full", 2);
        check("full_head", 64'(wb_id), 64'(1));
        offer(3'd3, 64'hDEAD_BEEF_0000_0003, 1'b0);
        tick();
        idle_inputs();
        check_state("dropped", 2);
        check("dropped_head", 64'(wb_id), 64'(1));
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        check_state("after_full_ack", 1);
        check("after_full_ack_head", 64'(wb_id), 64'(2));
        drain();

        // Push and pop together with one entry held.
        offer(3'd4, 64'h4010_0000_0000_0004, 1'b1);
        tick();
        idle_inputs();
        check_state("simul_pre", 1);
        check("simul_pre_head", 64'(wb_id), 64'(4));
        offer(3'd6, 64'h4018_0000_0000_0006, 1'b1);
        ack_drv = 1'b1;
        tick();
        idle_inputs();
        check_state("simul_post", 1);
        check("simul_post_head", 64'(wb_id), 64'(6));
        drain();

        // Streaming with writeback acking done combinationally. Pointers wrap.
        ack_follow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("stream_ready_pre", 64'(result_ready), 64'(1));
            offer(ID_WIDTH'(i), 64'h4020_0000_0000_0000 + 64'(i) * 64'h0001_0000_0000_0011, 1'b1);
            tick();
            check_state("stream", 1);
            check("stream_head", 64'(wb_id), 64'(i));
        end
        idle_inputs();
        tick();
        check_state("stream_end", 0);
        ack_follow = 1'b0;

        // Spurious acks on an empty buffer, then a normal push.
        ack_drv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("spurious_count", 64'(count), 64'(0));
        end
        ack_drv = 1'b0;
        offer(3'd2, 64'h3FE0_0000_0000_0002, 1'b1);
        tick();
        idle_inputs();
        check_state("post_spurious", 1);
        check("post_spurious_id", 64'(wb_id), 64'(2));
        check("post_spurious_rd", wb_rd,      64'h3FE0_0000_0000_0002);
        drain();

        // Asynchronous reset with two entries buffered, between clock edges.
        offer(3'd7, 64'h7FF0_0000_0000_0007, 1'b1);
        tick();
        offer(3'd1, 64'h7FF8_0000_0000_0001, 1'b1);
        tick();
        idle_inputs();
        check_state("pre_reset", 2);
        #2 rst = 1'b1;
        #1;
        check_state("async_reset", 0);
        check("async_reset_id", 64'(wb_id), 64'(0));
        check("async_reset_rd", wb_rd,      64'(0));
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        check_state("post_reset", 0);
        offer(3'd3, 64'h0000_0000_0000_0033, 1'b1);
        tick();
        idle_inputs();
        check_state("post_reset_push", 1);
        check("post_reset_id", 64'(wb_id), 64'(3));
        drain();

        tick();
        check("sb_leftover", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
